mm_interconnect: RTL

MM_INTERCONNECT -- requirements
Module: mm_interconnect

---
 rtl/mm_interconnect.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mm_interconnect.sv
// Memory-mapped interconnect: decodes a CPU request onto one of NUM_SLAVES
// one-hot slave selects, returns registered read data, and turns unmapped
// accesses and slave timeouts into a one-cycle error response.
module mm_interconnect #(
  parameter int unsigned                NUM_SLAVES     = 10,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = '0,
  parameter int unsigned                TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                ERR_RDATA      = 32'hBADB_ADBA
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      slv_sel,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  input  logic [NUM_SLAVES*32-1:0]   slv_data_o,
  output logic                       bus_err,
  output logic                       err_cause,
  output logic [31:0]                err_addr,
  output logic [15:0]                err_count
);

  localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_SLAVES-1:0]   slv_sel_q;
  logic                    mem_ready_q;
  logic [31:0]             mem_rdata_q;
  logic                    bus_err_q;
  logic                    err_cause_q;
  logic [31:0]             err_addr_q;
  logic [15:0]             err_count_q;
  logic [15:0]             tmo_q;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_oh;
  logic                    sel_ready;
  logic [31:0]             sel_data;
  logic [15:0]             err_count_d;

  // Write strobes pass straight to the slaves; nothing here consumes them.
  logic unused_wstrb;
  assign unused_wstrb = ^mem_wstrb;

  // Address decode; the first match scanning upward wins, so lowest index has priority.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((mem_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
        hit       = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Ready/data of the currently selected slave; all other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = slv_ready[i];
        sel_data  = slv_data_o[i*32 +: 32];
      end
    end
  end

  // Saturating error counter next value.
  always_comb begin
    err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      slv_sel_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      err_cause_q <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      tmo_q       <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              state_q   <= ACTIVE;
              idx_q     <= hit_idx;
              slv_sel_q <= hit_oh;
              tmo_q     <= '0;
            end else begin
              state_q     <= RESP;
              mem_ready_q <= 1'b1;
              mem_rdata_q <= ERR_RDATA;
              bus_err_q   <= 1'b1;
              err_cause_q <= 1'b0;
              err_addr_q  <= mem_addr;
              err_count_q <= err_count_d;
            end
          end
        end
        ACTIVE: begin
          if (!mem_valid) begin
            state_q   <= IDLE;
            slv_sel_q <= '0;
            tmo_q     <= '0;
          end else if (sel_ready) begin
            // Ready is checked before the timeout so a last-cycle ready completes normally.
            state_q     <= RESP;
            slv_sel_q   <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= sel_data;
            tmo_q       <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= RESP;
            slv_sel_q   <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= ERR_RDATA;
            bus_err_q   <= 1'b1;
            err_cause_q <= 1'b1;
            err_addr_q  <= mem_addr;
            err_count_q <= err_count_d;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          slv_sel_q <= '0;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign slv_sel   = slv_sel_q;
  assign bus_err   = bus_err_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule
